// File: rtl/serial_sync_ctrl.sv
// Serial byte-alignment controller: hunts for COM_BYTE, qualifies lock over LOCK_COUNT
// aligned COMs, then strobes aligned bytes. Optional macro COM_FILTER_EN drops COMs once locked.
module serial_sync_ctrl #(
    parameter logic [7:0]  COM_BYTE   = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       VALID,
    output logic       ACTIVE,
    output logic       SYNCING
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CHECK,
        ST_LOCKED
    } state_e;

`ifdef COM_FILTER_EN
    localparam bit FILTER_COM = 1'b1;
`else
    localparam bit FILTER_COM = 1'b0;
`endif

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_e     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, syncing_q;

    logic [7:0] cand;
    logic       boundary;
    logic       is_com;
    logic [3:0] com_cnt_inc;

    assign cand        = {sr_q[6:0], DATA_IN};
    assign boundary    = (bit_cnt_q == 3'd7);
    assign is_com      = (cand == COM_BYTE);
    assign com_cnt_inc = com_cnt_q + 4'd1;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sr_d      = cand;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    state_d   = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_inc;
                        if (com_cnt_inc == LOCK_CNT) state_d = ST_LOCKED;
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                // A filtered COM leaves the byte phase running but produces no strobe.
                if (boundary && !(FILTER_COM && is_com)) begin
                    data_d  = cand;
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_HUNT;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            syncing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= (state_d == ST_LOCKED);
            syncing_q <= (state_d == ST_CHECK);
        end
    end

    assign DATA_OUT = data_q;
    assign VALID    = valid_q;
    assign ACTIVE   = active_q;
    assign SYNCING  = syncing_q;

endmodule

// File: tb/tb_serial_sync_ctrl.sv
// Bench for serial_sync_ctrl: directed scenarios plus random streams, every edge compared
// against a model that tracks byte boundaries as absolute edge numbers over the bit history.
module tb_serial_sync_ctrl;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         LC  = 4;
`ifdef COM_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DATA_IN = 1'b0;
    logic [7:0] DATA_OUT;
    logic       VALID, ACTIVE, SYNCING;

    serial_sync_ctrl #(.COM_BYTE(COM), .LOCK_COUNT(LC)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .VALID(VALID), .ACTIVE(ACTIVE), .SYNCING(SYNCING)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;

    // Reference model: mode 0 = searching, 1 = qualifying, 2 = locked.
    bit         hist[$];
    int         m_mode = 0;
    int         m_coms = 0;
    int         m_next = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic r);
        logic [7:0] cand;
        int         e;
        DATA_IN = b;
        RESET   = r;
        @(posedge CLK);
        m_valid = 1'b0;
        if (r) begin
            hist.delete();
            m_mode = 0;
            m_coms = 0;
            m_data = 8'h00;
        end else begin
            hist.push_back(b);
            e    = hist.size() - 1;
            cand = 8'h00;
            for (int i = 0; i < 8; i++)
                if (e - 7 + i >= 0) cand[7 - i] = hist[e - 7 + i];
            if (m_mode == 0) begin
                if (cand == COM) begin
                    m_coms = 1;
                    m_next = e + 8;
                    m_mode = (LC == 1) ? 2 : 1;
                end
            end else if (e == m_next) begin
                m_next = e + 8;
                if (m_mode == 1) begin
                    if (cand == COM) begin
                        m_coms++;
                        if (m_coms == LC) m_mode = 2;
                    end else begin
                        m_coms = 0;
                        m_mode = 0;
                    end
                end else if (!(FILT && cand == COM)) begin
                    m_data  = cand;
                    m_valid = 1'b1;
                end
            end
        end
        #1;
        if (VALID === 1'b1) valid_seen++;
        check("valid",   {7'd0, VALID},   {7'd0, m_valid});
        check("data",    DATA_OUT,        m_data);
        check("active",  {7'd0, ACTIVE},  {7'd0, m_mode == 2});
        check("syncing", {7'd0, SYNCING}, {7'd0, m_mode == 1});
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom), 1'b1);
    endtask

    int v0;

    initial begin
        // Reset with random serial data
        do_reset(2);
        check("rst_data",  DATA_OUT, 8'h00);
        check("rst_flags", {5'd0, VALID, ACTIVE, SYNCING}, 8'h00);

        // Lock and data
        for (int i = 0; i < 3; i++) step(1'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) send_byte(COM);
        check("pre_lock_active",  {7'd0, ACTIVE},  8'h00);
        check("pre_lock_syncing", {7'd0, SYNCING}, 8'h01);
        send_byte(COM);
        check("lock_active", {7'd0, ACTIVE}, 8'h01);
        v0 = valid_seen;
        send_byte(8'hA5);
        check("data_a5", DATA_OUT, 8'hA5);
        check("data_a5_valid", {7'd0, VALID}, 8'h01);
        send_byte(8'h3C);
        check("data_3c", DATA_OUT, 8'h3C);
        check("two_pulses", 8'(valid_seen - v0), 8'd2);

        // COM filter behaviour in LOCKED
        v0 = valid_seen;
        send_byte(8'h11);
        send_byte(COM);
        send_byte(8'h22);
        check("filter_pulses", 8'(valid_seen - v0), FILT ? 8'd2 : 8'd3);
        check("filter_last", DATA_OUT, 8'h22);

        // Broken run then relock
        do_reset(1);
        send_byte(COM);
        send_byte(COM);
        check("broken_sync", {7'd0, SYNCING}, 8'h01);
        send_byte(8'h55);
        check("broken_drop", {6'd0, SYNCING, ACTIVE}, 8'h00);
        for (int i = 0; i < 4; i++) send_byte(COM);
        check("relock", {7'd0, ACTIVE}, 8'h01);
        send_byte(8'h0F);
        check("relock_data", DATA_OUT, 8'h0F);

        // COM shifted by 5 bits
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) send_byte(COM);
        send_byte(8'h96);
        check("shift_data", DATA_OUT, 8'h96);

        // Reset three bits into a data byte
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        v0 = valid_seen;
        do_reset(1);
        check("midrst_flags", {5'd0, VALID, ACTIVE, SYNCING}, 8'h00);
        check("midrst_data", DATA_OUT, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        check("midrst_nopulse", 8'(valid_seen - v0), 8'd0);
        for (int i = 0; i < 3; i++) send_byte(COM);
        check("midrst_not_locked", {7'd0, ACTIVE}, 8'h00);
        send_byte(COM);
        check("midrst_relock", {7'd0, ACTIVE}, 8'h01);

        // Random streams: noise hunt, then lock and random payload with occasional COMs
        for (int r = 0; r < 6; r++) begin
            do_reset(1 + ($urandom % 2));
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) step(1'($urandom), 1'b0);
            for (int i = 0; i < 4; i++) send_byte(COM);
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 3) == 0) send_byte(COM);
                else send_byte(8'($urandom));
            end
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) step(1'($urandom), 1'b0);
        end
        do_reset(1);
        for (int i = 0; i < 400; i++) step(1'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
